mlp_seq_controller: RTL and testbench
=====================================

Name: mlp_seq_controller

Overview:
- Parametrised successor to the fixed 784/200/10 two-layer MLP sequencer.
- Drives the layer-1 MAC lanes, the 16-bit activation register holder, the activation LUT, the layer-2 weight memory and the layer-2 accumulator SRAM (GSRAM).
- Adds a start/done/busy handshake, an in_valid stall during layer-1 accumulation, and a first-pass clear of GSRAM, replacing the free-running counters.
- Sits between the top-level sequencer and the datapath.

Parameters:
N_IN, 784, layer-1 inputs per hidden neuron
N_LANES, 10, parallel layer-1 MACs (hidden neurons per group)
N_GROUPS, 20, layer-1 groups (hidden size = N_LANES*N_GROUPS)
N_OUT, 10, layer-2 outputs
Derived widths: IW=clog2(N_IN), LW=clog2(N_LANES), GW=clog2(N_GROUPS), OW=clog2(N_OUT), HW=clog2(N_LANES*N_GROUPS); each is at least 1.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start  in  1  begin one inference; sampled only in IDLE
in_valid  in  1  layer-1 operand valid; low = stall
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse in DONE
mac_reset  out  1  clear layer-1 MAC accumulators
mac_en  out  1  layer-1 MAC accumulate enable
in_addr  out  IW  layer-1 input/weight index k
group_idx  out  GW  current group g
reg_holder_in  out  1  reg holder write enable
reg_holder_mux  out  1  0 = load all lanes from MACs; 1 = load lane from LUT
reg_holder_addr  out  LW  lane index
lut_mux  out  1  0 = LUT source is reg holder; 1 = LUT source is GSRAM
weight2_row  out  HW  g*N_LANES+l
weight2_col  out  OW  output index o
gsram_addr  out  OW  GSRAM entry
gsram_in  out  1  GSRAM write enable
gsram_mux  out  1  0 = write adder result; 1 = write LUT result
gsram_clear  out  1  adder uses 0 instead of the GSRAM read value

Behaviour:
- Output decode: all outputs decode from registered state and counters. Every output is 0 in IDLE, except mac_reset=start.
- Reset: reset at an edge forces IDLE and clears counters k, j, l, o, g. This holds mid-operation; no partial results are flushed.
- IDLE: if start=1, go to L1_ACC with all counters 0. start is ignored in all other states.
- L1_ACC:
  - in_addr=k, group_idx=g, mac_en=in_valid.
  - k advances only when in_valid=1.
  - in_valid=1 with k=N_IN-1: go to L1_CAP and set k=0.
  - in_valid=0 holds state and k.
- L1_CAP (1 cycle): reg_holder_in=1, reg_holder_mux=0, mac_reset=1. Go to ACT_RD with j=0.
- ACT_RD: reg_holder_addr=j, lut_mux=0. Go to ACT_WR.
- ACT_WR: reg_holder_in=1, reg_holder_mux=1, reg_holder_addr=j.
  - j=N_LANES-1: go to L2_RD with l=0, o=0.
  - Otherwise j+1, back to ACT_RD.
- L2_RD: gsram_addr=o, reg_holder_addr=l, weight2_row=g*N_LANES+l, weight2_col=o. Go to L2_WR.
- L2_WR:
  - Same addresses as L2_RD, plus gsram_in=1, gsram_mux=0, gsram_clear=(g==0 && l==0).
  - Loop order: o innermost, then l.
  - On the last pair: if g=N_GROUPS-1, go to FIN_RD with o=0. Otherwise g+1 and go to L1_ACC.
- FIN_RD: gsram_addr=o. Go to FIN_LUT.
- FIN_LUT: gsram_addr=o, lut_mux=1. Go to FIN_WR.
- FIN_WR: gsram_addr=o, gsram_in=1, gsram_mux=1.
  - o=N_OUT-1: go to DONE.
  - Otherwise o+1, back to FIN_RD.
- DONE: done=1 and busy=1. Go to IDLE. A back-to-back start is accepted in the following IDLE cycle.
- Latency with in_valid held high, counting the first L1_ACC cycle as cycle 1:
  - Per group: N_IN + 1 + 2*N_LANES + 2*N_LANES*N_OUT cycles.
  - Finalise: 3*N_OUT cycles.
  - done appears in the next cycle.
  - Defaults: 1005 per group, done in cycle 20131.
- Counter wrap: each counter returns exactly to 0 at its terminal value and never exceeds it. This holds for non-power-of-2 parameters.

Test Plan:
1. Small config N_IN=4, N_LANES=2, N_GROUPS=2, N_OUT=3, in_valid=1, start pulsed once -> done only in cycle 52; busy high cycles 1-52; exactly 2 L1_CAP cycles.
2. Same config, in_valid low for 3 cycles at k=2 -> in_addr holds 2 and mac_en=0 during the stall; done moves to cycle 55.
3. Same config, check the L2_WR sequence -> 12 gsram_in pulses with (row,col) order (0,0),(0,1),(0,2),(1,0)... then (2,0)...(3,2); gsram_clear=1 only on the first 3 writes.
4. Reset asserted in group 1 L2_RD, then start -> outputs 0 the next cycle; a full clean run completes with done in cycle 52.
5. start held high continuously -> second run begins in the cycle after DONE+IDLE; start pulses during busy have no effect.
6. Defaults, in_valid=1 -> done in cycle 20131; in_addr reaches 783 and wraps to 0; group_idx reaches 19; 10 FIN_WR writes with gsram_mux=1.

Source files
------------

// File: rtl/mlp_seq_controller.sv
// ---------------------------------------------------------------------------
// mlp_seq_controller
//
// Sequencer for a parametrised two-layer MLP datapath. One inference is
// launched with start. For each of N_GROUPS hidden-neuron groups it does
// four things in order:
//   1. Accumulates N_IN layer-1 products into N_LANES MACs. in_valid stalls
//      this phase.
//   2. Captures the MAC results into the register holder.
//   3. Passes each lane through the activation LUT.
//   4. Accumulates the lane contributions into the layer-2 GSRAM.
// A final pass then runs every GSRAM entry through the LUT.
//
// Ports
//   clk, reset      clock, synchronous active-high reset
//   start           begin one inference (sampled only when idle)
//   in_valid        layer-1 operand valid; low stalls the accumulation
//   busy, done      handshake: busy outside IDLE, done one-cycle pulse
//   mac_reset       clear layer-1 MAC accumulators
//   mac_en          layer-1 MAC accumulate enable
//   in_addr         layer-1 input/weight index k
//   group_idx       current hidden group g
//   reg_holder_*    register holder write enable / source mux / lane index
//   lut_mux         LUT source: 0 register holder, 1 GSRAM
//   weight2_row/col layer-2 weight address (hidden index, output index)
//   gsram_*         GSRAM address / write enable / source mux / clear
// ---------------------------------------------------------------------------
module mlp_seq_controller #(
    parameter int N_IN     = 784,
    parameter int N_LANES  = 10,
    parameter int N_GROUPS = 20,
    parameter int N_OUT    = 10,
    localparam int IW = (N_IN > 1)               ? $clog2(N_IN)               : 1,
    localparam int LW = (N_LANES > 1)            ? $clog2(N_LANES)            : 1,
    localparam int GW = (N_GROUPS > 1)           ? $clog2(N_GROUPS)           : 1,
    localparam int OW = (N_OUT > 1)              ? $clog2(N_OUT)              : 1,
    localparam int HW = (N_LANES * N_GROUPS > 1) ? $clog2(N_LANES * N_GROUPS) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          in_valid,
    output logic          busy,
    output logic          done,
    output logic          mac_reset,
    output logic          mac_en,
    output logic [IW-1:0] in_addr,
    output logic [GW-1:0] group_idx,
    output logic          reg_holder_in,
    output logic          reg_holder_mux,
    output logic [LW-1:0] reg_holder_addr,
    output logic          lut_mux,
    output logic [HW-1:0] weight2_row,
    output logic [OW-1:0] weight2_col,
    output logic [OW-1:0] gsram_addr,
    output logic          gsram_in,
    output logic          gsram_mux,
    output logic          gsram_clear
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_L1_ACC,
        S_L1_CAP,
        S_ACT_RD,
        S_ACT_WR,
        S_L2_RD,
        S_L2_WR,
        S_FIN_RD,
        S_FIN_LUT,
        S_FIN_WR,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [IW-1:0] k;
    logic [LW-1:0] j;
    logic [LW-1:0] l;
    logic [OW-1:0] o;
    logic [GW-1:0] g;

    logic k_last, j_last, l_last, o_last, g_last;

    // Terminal values are compared exactly, so non-power-of-2 sizes wrap cleanly.
    assign k_last = (k == IW'(N_IN - 1));
    assign j_last = (j == LW'(N_LANES - 1));
    assign l_last = (l == LW'(N_LANES - 1));
    assign o_last = (o == OW'(N_OUT - 1));
    assign g_last = (g == GW'(N_GROUPS - 1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start) state_nxt = S_L1_ACC;
            S_L1_ACC:  if (in_valid && k_last) state_nxt = S_L1_CAP;
            S_L1_CAP:  state_nxt = S_ACT_RD;
            S_ACT_RD:  state_nxt = S_ACT_WR;
            S_ACT_WR:  state_nxt = j_last ? S_L2_RD : S_ACT_RD;
            S_L2_RD:   state_nxt = S_L2_WR;
            S_L2_WR: begin
                if (o_last && l_last) state_nxt = g_last ? S_FIN_RD : S_L1_ACC;
                else                  state_nxt = S_L2_RD;
            end
            S_FIN_RD:  state_nxt = S_FIN_LUT;
            S_FIN_LUT: state_nxt = S_FIN_WR;
            S_FIN_WR:  state_nxt = o_last ? S_DONE : S_FIN_RD;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Loop counters. Each one is cleared on the transition that enters its
    // loop, so every loop starts from 0 regardless of how the last one ended.
    always_ff @(posedge clk) begin
        if (reset) begin
            k <= '0;
            j <= '0;
            l <= '0;
            o <= '0;
            g <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        k <= '0;
                        j <= '0;
                        l <= '0;
                        o <= '0;
                        g <= '0;
                    end
                end
                S_L1_ACC: begin
                    if (in_valid) k <= k_last ? '0 : k + IW'(1);
                end
                S_L1_CAP: j <= '0;
                S_ACT_WR: begin
                    if (j_last) begin
                        l <= '0;
                        o <= '0;
                    end else begin
                        j <= j + LW'(1);
                    end
                end
                S_L2_WR: begin
                    // o is the inner loop, l the outer; g advances once per group.
                    if (o_last) begin
                        o <= '0;
                        if (l_last) begin
                            l <= '0;
                            if (!g_last) g <= g + GW'(1);
                        end else begin
                            l <= l + LW'(1);
                        end
                    end else begin
                        o <= o + OW'(1);
                    end
                end
                S_FIN_WR: o <= o_last ? '0 : o + OW'(1);
                S_DONE: begin
                    k <= '0;
                    j <= '0;
                    l <= '0;
                    o <= '0;
                    g <= '0;
                end
                default: ;
            endcase
        end
    end

    // Output decode
    always_comb begin
        done            = 1'b0;
        mac_reset       = 1'b0;
        mac_en          = 1'b0;
        in_addr         = '0;
        group_idx       = '0;
        reg_holder_in   = 1'b0;
        reg_holder_mux  = 1'b0;
        reg_holder_addr = '0;
        lut_mux         = 1'b0;
        weight2_row     = '0;
        weight2_col     = '0;
        gsram_addr      = '0;
        gsram_in        = 1'b0;
        gsram_mux       = 1'b0;
        gsram_clear     = 1'b0;
        case (state)
            // Clearing the MACs as start is accepted gives group 0 a clean slate.
            S_IDLE: mac_reset = start;
            S_L1_ACC: begin
                in_addr   = k;
                group_idx = g;
                mac_en    = in_valid;
            end
            S_L1_CAP: begin
                reg_holder_in = 1'b1;
                mac_reset     = 1'b1;
            end
            S_ACT_RD: reg_holder_addr = j;
            S_ACT_WR: begin
                reg_holder_in   = 1'b1;
                reg_holder_mux  = 1'b1;
                reg_holder_addr = j;
            end
            S_L2_RD, S_L2_WR: begin
                gsram_addr      = o;
                reg_holder_addr = l;
                weight2_row     = HW'(g) * HW'(N_LANES) + HW'(l);
                weight2_col     = o;
                if (state == S_L2_WR) begin
                    gsram_in = 1'b1;
                    // The first lane of the first group overwrites stale GSRAM
                    // contents rather than adding to them.
                    gsram_clear = (g == '0) && (l == '0);
                end
            end
            S_FIN_RD: gsram_addr = o;
            S_FIN_LUT: begin
                gsram_addr = o;
                lut_mux    = 1'b1;
            end
            S_FIN_WR: begin
                gsram_addr = o;
                gsram_in   = 1'b1;
                gsram_mux  = 1'b1;
            end
            S_DONE: done = 1'b1;
            default: ;
        endcase
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_mlp_seq_controller.sv
// ---------------------------------------------------------------------------
// tb_mlp_seq_controller
//
// Runs a small configuration (4/2/2/3) and the default configuration of the
// sequencer. A loop-nest reference model walks the inference schedule and
// compares the full output vector on every cycle. It also randomises
// in_valid stalls and start activity while the sequencer is busy.
// ---------------------------------------------------------------------------
module tb_mlp_seq_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // Small instance: N_IN=4, N_LANES=2, N_GROUPS=2, N_OUT=3
    logic       start_s, iv_s;
    logic       busy_s, done_s, mac_reset_s, mac_en_s;
    logic [1:0] in_addr_s;
    logic [0:0] group_idx_s;
    logic       rh_in_s, rh_mux_s;
    logic [0:0] rh_addr_s;
    logic       lut_mux_s;
    logic [1:0] w2_row_s;
    logic [1:0] w2_col_s;
    logic [1:0] g_addr_s;
    logic       g_in_s, g_mux_s, g_clr_s;

    // Default instance: 784/10/20/10
    logic       start_d, iv_d;
    logic       busy_d, done_d, mac_reset_d, mac_en_d;
    logic [9:0] in_addr_d;
    logic [4:0] group_idx_d;
    logic       rh_in_d, rh_mux_d;
    logic [3:0] rh_addr_d;
    logic       lut_mux_d;
    logic [7:0] w2_row_d;
    logic [3:0] w2_col_d;
    logic [3:0] g_addr_d;
    logic       g_in_d, g_mux_d, g_clr_d;

    mlp_seq_controller #(.N_IN(4), .N_LANES(2), .N_GROUPS(2), .N_OUT(3)) u_small (
        .clk(clk), .reset(reset), .start(start_s), .in_valid(iv_s),
        .busy(busy_s), .done(done_s), .mac_reset(mac_reset_s), .mac_en(mac_en_s),
        .in_addr(in_addr_s), .group_idx(group_idx_s),
        .reg_holder_in(rh_in_s), .reg_holder_mux(rh_mux_s), .reg_holder_addr(rh_addr_s),
        .lut_mux(lut_mux_s), .weight2_row(w2_row_s), .weight2_col(w2_col_s),
        .gsram_addr(g_addr_s), .gsram_in(g_in_s), .gsram_mux(g_mux_s), .gsram_clear(g_clr_s)
    );

    mlp_seq_controller u_dflt (
        .clk(clk), .reset(reset), .start(start_d), .in_valid(iv_d),
        .busy(busy_d), .done(done_d), .mac_reset(mac_reset_d), .mac_en(mac_en_d),
        .in_addr(in_addr_d), .group_idx(group_idx_d),
        .reg_holder_in(rh_in_d), .reg_holder_mux(rh_mux_d), .reg_holder_addr(rh_addr_d),
        .lut_mux(lut_mux_d), .weight2_row(w2_row_d), .weight2_col(w2_col_d),
        .gsram_addr(g_addr_d), .gsram_in(g_in_d), .gsram_mux(g_mux_d), .gsram_clear(g_clr_d)
    );

    int n_tests, n_fail;
    int cnt, dut_done, n_l1cap, n_wr, n_clr, n_fin, max_ia, max_gi;

    // Packed output vector: 10 flag bits, then in_addr(10) group(5) lane(4)
    // row(8) col(4) gsram_addr(4).
    function automatic logic [63:0] pk(
        input int busy, input int done, input int mr, input int me,
        input int rhi, input int rhm, input int lm, input int gin, input int gm, input int gc,
        input int ia, input int gi, input int rha, input int row, input int col, input int ga);
        return {19'b0, busy[0], done[0], mr[0], me[0], rhi[0], rhm[0], lm[0], gin[0],
                gm[0], gc[0], ia[9:0], gi[4:0], rha[3:0], row[7:0], col[3:0], ga[3:0]};
    endfunction

    function automatic logic [63:0] got(input int sel);
        if (sel == 0)
            return pk(int'(busy_s), int'(done_s), int'(mac_reset_s), int'(mac_en_s),
                      int'(rh_in_s), int'(rh_mux_s), int'(lut_mux_s), int'(g_in_s),
                      int'(g_mux_s), int'(g_clr_s), int'(in_addr_s), int'(group_idx_s),
                      int'(rh_addr_s), int'(w2_row_s), int'(w2_col_s), int'(g_addr_s));
        return pk(int'(busy_d), int'(done_d), int'(mac_reset_d), int'(mac_en_d),
                  int'(rh_in_d), int'(rh_mux_d), int'(lut_mux_d), int'(g_in_d),
                  int'(g_mux_d), int'(g_clr_d), int'(in_addr_d), int'(group_idx_d),
                  int'(rh_addr_d), int'(w2_row_d), int'(w2_col_d), int'(g_addr_d));
    endfunction

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cnt);
        end
    endtask

    task automatic drv(input int sel, input bit st, input bit iv);
        if (sel == 0) begin start_s = st; iv_s = iv; end
        else          begin start_d = st; iv_d = iv; end
    endtask

    task automatic rnd(input int sel, input bit hold);
        drv(sel, hold ? 1'b1 : ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1));
    endtask

    // Inputs for the cycle are already driven at the falling edge. Compare
    // the outputs, tally the events, then advance one cycle.
    task automatic cyc(input int sel, input logic [63:0] exp, input string tag, input bit rst_after);
        logic [63:0] v;
        #1;
        cnt++;
        v = got(sel);
        chk(tag, v, exp);
        if (v[43] && dut_done < 0) dut_done = cnt;
        if (v[42] && v[40] && !v[39]) n_l1cap++;
        if (v[37] && !v[36]) n_wr++;
        if (v[35]) n_clr++;
        if (v[37] && v[36]) n_fin++;
        if (int'(v[34:25]) > max_ia) max_ia = int'(v[34:25]);
        if (int'(v[24:20]) > max_gi) max_gi = int'(v[24:20]);
        if (rst_after) reset = 1'b1;
        @(negedge clk);
    endtask

    // mode 0: in_valid always high; 1: random stalls; 2: 3-cycle stall at g=0,k=2.
    task automatic run(input int sel, input int n_in, input int nl, input int ng, input int no,
                       input int mode, input bit hold, input int abort_g, output int mdone);
        int  stalls;
        bit  iv;
        stalls = 0;
        cnt = -1; dut_done = -1;
        n_l1cap = 0; n_wr = 0; n_clr = 0; n_fin = 0; max_ia = 0; max_gi = 0;
        drv(sel, 1'b1, 1'b0);
        cyc(sel, pk(0,0,1,0, 0,0,0,0,0,0, 0,0,0,0,0,0), "idle_start", 1'b0);
        for (int g = 0; g < ng; g++) begin
            for (int k = 0; k < n_in; k++) begin
                do begin
                    if (mode == 0)      iv = 1'b1;
                    else if (mode == 1) iv = ($urandom_range(0, 3) != 0);
                    else                iv = !(g == 0 && k == 2 && stalls < 3);
                    if (!iv) stalls++;
                    drv(sel, hold ? 1'b1 : ($urandom_range(0, 1) == 1), iv);
                    cyc(sel, pk(1,0,0,int'(iv), 0,0,0,0,0,0, k,g,0,0,0,0), "l1_acc", 1'b0);
                end while (!iv);
            end
            rnd(sel, hold);
            cyc(sel, pk(1,0,1,0, 1,0,0,0,0,0, 0,0,0,0,0,0), "l1_cap", 1'b0);
            for (int j = 0; j < nl; j++) begin
                rnd(sel, hold);
                cyc(sel, pk(1,0,0,0, 0,0,0,0,0,0, 0,0,j,0,0,0), "act_rd", 1'b0);
                rnd(sel, hold);
                cyc(sel, pk(1,0,0,0, 1,1,0,0,0,0, 0,0,j,0,0,0), "act_wr", 1'b0);
            end
            for (int l = 0; l < nl; l++) begin
                for (int o = 0; o < no; o++) begin
                    rnd(sel, hold);
                    if (g == abort_g && l == 0 && o == 0) begin
                        cyc(sel, pk(1,0,0,0, 0,0,0,0,0,0, 0,0,l,g*nl+l,o,o), "l2_rd", 1'b1);
                        reset = 1'b0;
                        drv(sel, 1'b0, 1'b0);
                        cyc(sel, 64'd0, "after_rst", 1'b0);
                        mdone = -1;
                        return;
                    end
                    cyc(sel, pk(1,0,0,0, 0,0,0,0,0,0, 0,0,l,g*nl+l,o,o), "l2_rd", 1'b0);
                    rnd(sel, hold);
                    cyc(sel, pk(1,0,0,0, 0,0,0,1,0,int'(g == 0 && l == 0), 0,0,l,g*nl+l,o,o),
                        "l2_wr", 1'b0);
                end
            end
        end
        for (int o = 0; o < no; o++) begin
            rnd(sel, hold);
            cyc(sel, pk(1,0,0,0, 0,0,0,0,0,0, 0,0,0,0,0,o), "fin_rd", 1'b0);
            rnd(sel, hold);
            cyc(sel, pk(1,0,0,0, 0,0,1,0,0,0, 0,0,0,0,0,o), "fin_lut", 1'b0);
            rnd(sel, hold);
            cyc(sel, pk(1,0,0,0, 0,0,0,1,1,0, 0,0,0,0,0,o), "fin_wr", 1'b0);
        end
        rnd(sel, hold);
        cyc(sel, pk(1,1,0,0, 0,0,0,0,0,0, 0,0,0,0,0,0), "done", 1'b0);
        mdone = cnt;
        drv(sel, 1'b0, 1'b0);
    endtask

    initial begin
        int md;
        n_tests = 0; n_fail = 0; cnt = 0;
        reset = 1'b1;
        drv(0, 1'b0, 1'b0);
        drv(1, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_small_idle", got(0), 64'd0);
        chk("rst_dflt_idle", got(1), 64'd0);
        // start while reset is held must not launch a run
        start_s = 1'b1;
        #1;
        chk("idle_mac_reset", got(0), pk(0,0,1,0, 0,0,0,0,0,0, 0,0,0,0,0,0));
        @(negedge clk);
        start_s = 1'b0;
        #1;
        chk("rst_blocks_start", got(0), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Small config, in_valid high
        run(0, 4, 2, 2, 3, 0, 1'b0, -1, md);
        chk("t1_done_cycle", 64'(dut_done), 64'd52);
        chk("t1_l1cap", 64'(n_l1cap), 64'd2);
        chk("t3_gsram_writes", 64'(n_wr), 64'd12);
        chk("t3_gsram_clears", 64'(n_clr), 64'd3);
        chk("t1_fin_writes", 64'(n_fin), 64'd3);

        // Three-cycle stall at k=2
        run(0, 4, 2, 2, 3, 2, 1'b0, -1, md);
        chk("t2_done_cycle", 64'(dut_done), 64'd55);

        // Random stalls and random start during busy
        for (int r = 0; r < 3; r++) begin
            run(0, 4, 2, 2, 3, 1, 1'b0, -1, md);
            chk("rand_done_cycle", 64'(dut_done), 64'(md));
        end

        // Reset in group 1 L2_RD, then a clean run
        run(0, 4, 2, 2, 3, 0, 1'b0, 1, md);
        run(0, 4, 2, 2, 3, 0, 1'b0, -1, md);
        chk("t4_done_cycle", 64'(dut_done), 64'd52);

        // start held high: back-to-back runs
        run(0, 4, 2, 2, 3, 0, 1'b1, -1, md);
        chk("t5_first_done", 64'(dut_done), 64'd52);
        run(0, 4, 2, 2, 3, 0, 1'b1, -1, md);
        chk("t5_second_done", 64'(dut_done), 64'd52);
        #1;
        chk("t5_idle_after", got(0), 64'd0);

        // Default configuration
        run(1, 784, 10, 20, 10, 0, 1'b0, -1, md);
        chk("t6_done_cycle", 64'(dut_done), 64'd20131);
        chk("t6_max_in_addr", 64'(max_ia), 64'd783);
        chk("t6_max_group", 64'(max_gi), 64'd19);
        chk("t6_fin_writes", 64'(n_fin), 64'd10);
        chk("t6_l1cap", 64'(n_l1cap), 64'd20);
        chk("t6_gsram_writes", 64'(n_wr), 64'd2000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
